// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device responder: command codes, mode fields,
// burst/latency decode and error flag positions.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = 4'b0000,
        CMD_REFRESH    = 4'b0001,
        CMD_PRECHARGE  = 4'b0010,
        CMD_ACTIVE     = 4'b0011,
        CMD_WRITE      = 4'b0100,
        CMD_READ       = 4'b0101,
        CMD_BURST_TERM = 4'b0110,
        CMD_NOP        = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [1:0] {
        BURST_IDLE,
        BURST_READ,
        BURST_WRITE
    } burst_state_e;

    localparam int unsigned MODE_BL_LSB = 0;
    localparam int unsigned MODE_CL_LSB = 4;
    localparam int unsigned A_AP_BIT    = 10;

    localparam int unsigned ERR_CLOSED  = 0;
    localparam int unsigned ERR_REOPEN  = 1;
    localparam int unsigned ERR_TRCD    = 2;
    localparam int unsigned ERR_W       = 3;

    // Burst length is kept as log2(BL) so it doubles as the wrap mask width.
    function automatic logic [1:0] bl_log2(input logic [2:0] code);
        case (code)
            3'd1:    return 2'd1;
            3'd2:    return 2'd2;
            3'd3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] cl_decode(input logic [2:0] code);
        return (code == 3'd2) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sdram_bank_state.sv
// Per-bank state: open flag, open row, tRCD down-counter and pending
// auto-precharge.
module sdram_bank_state #(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned TRCD     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cke,
    input  logic                act,
    input  logic                pre,
    input  logic                rw,
    input  logic                ap,
    input  logic                fire,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                is_open,
    output logic [ROW_BITS-1:0] row,
    output logic                trcd_busy
);

    localparam int unsigned CW = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam logic [CW-1:0] TRCD_LOAD = CW'(TRCD - 1);

    logic [CW-1:0] trcd_cnt;
    logic          ap_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_open    <= 1'b0;
            row        <= '0;
            trcd_cnt   <= '0;
            ap_pending <= 1'b0;
        end else if (cke) begin
            if (act) begin
                is_open    <= 1'b1;
                row        <= row_in;
                trcd_cnt   <= TRCD_LOAD;
                ap_pending <= 1'b0;
            end else begin
                if (trcd_cnt != '0)
                    trcd_cnt <= trcd_cnt - CW'(1);
                // A one-word auto-precharge burst finishes on its own command edge.
                if (pre) begin
                    is_open    <= 1'b0;
                    ap_pending <= 1'b0;
                end else if (rw) begin
                    if (ap && fire)
                        is_open <= 1'b0;
                    ap_pending <= ap && !fire;
                end else if (fire && ap_pending) begin
                    is_open    <= 1'b0;
                    ap_pending <= 1'b0;
                end
            end
        end
    end

    assign trcd_busy = (trcd_cnt != '0);

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model: decodes controller commands, tracks banks, and serves
// burst reads/writes from an internal array with programmable CL and BL.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS = 2,
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned TRCD     = 2
) (
    input  logic        sdram_clk,
    input  logic        rst_n,
    input  logic        sdram_cke,
    input  logic        sdram_csn,
    input  logic        sdram_rasn,
    input  logic        sdram_casn,
    input  logic        sdram_wen,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_d_i,
    output logic [15:0] sdram_d_o,
    output logic        sdram_d_oe,
    output logic        mode_valid,
    output logic [2:0]  err
);

    localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << AW;

    sdram_cmd_e cmd;
    logic       cmd_en, is_load, is_act, is_rd, is_wr, is_rw, is_pre, is_bt;

    assign cmd     = sdram_cmd_e'({sdram_csn, sdram_rasn, sdram_casn, sdram_wen});
    assign cmd_en  = sdram_cke && !sdram_csn;
    assign is_load = cmd_en && (cmd == CMD_LOAD_MODE);
    assign is_act  = cmd_en && (cmd == CMD_ACTIVE);
    assign is_rd   = cmd_en && (cmd == CMD_READ);
    assign is_wr   = cmd_en && (cmd == CMD_WRITE);
    assign is_pre  = cmd_en && (cmd == CMD_PRECHARGE);
    assign is_bt   = cmd_en && (cmd == CMD_BURST_TERM);
    assign is_rw   = is_rd || is_wr;

    logic unused_bits;
    assign unused_bits = ^sdram_a;

    logic [1:0] bl_lg;
    logic [1:0] cas_lat;

    burst_state_e        b_state, b_state_n;
    logic [1:0]          b_bank, b_bank_n;
    logic [ROW_BITS-1:0] b_row, b_row_n;
    logic [COL_BITS-1:0] b_col, b_col_n;
    logic [2:0]          b_left, b_left_n;
    logic [1:0]          b_lg, b_lg_n;
    logic                issue_rd, issue_wr, burst_done;
    logic [1:0]          done_bank;
    logic [AW-1:0]       issue_addr;

    logic [3:0]          bank_open, bank_busy, bank_act, bank_pre, bank_rw, bank_fire;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [ROW_BITS-1:0] cmd_row;
    logic [COL_BITS-1:0] cmd_col;

    assign cmd_row = bank_open[sdram_ba] ? bank_row[sdram_ba] : '0;
    assign cmd_col = sdram_a[COL_BITS-1:0];

    always_comb begin
        bank_act  = '0;
        bank_pre  = '0;
        bank_rw   = '0;
        bank_fire = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            bank_act[i]  = is_act && (sdram_ba == 2'(i));
            bank_pre[i]  = is_pre && (sdram_a[A_AP_BIT] || (sdram_ba == 2'(i)));
            bank_rw[i]   = is_rw && (sdram_ba == 2'(i));
            bank_fire[i] = burst_done && (done_bank == 2'(i));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_bank_state #(
            .ROW_BITS(ROW_BITS),
            .TRCD    (TRCD)
        ) u_bank (
            .clk      (sdram_clk),
            .rst_n    (rst_n),
            .cke      (sdram_cke),
            .act      (bank_act[g]),
            .pre      (bank_pre[g]),
            .rw       (bank_rw[g]),
            .ap       (sdram_a[A_AP_BIT]),
            .fire     (bank_fire[g]),
            .row_in   (sdram_a[ROW_BITS-1:0]),
            .is_open  (bank_open[g]),
            .row      (bank_row[g]),
            .trcd_busy(bank_busy[g])
        );
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_valid <= 1'b0;
            bl_lg      <= 2'd0;
            cas_lat    <= 2'd3;
            err        <= '0;
        end else begin
            if (is_load) begin
                bl_lg      <= bl_log2(sdram_a[MODE_BL_LSB +: 3]);
                cas_lat    <= cl_decode(sdram_a[MODE_CL_LSB +: 3]);
                mode_valid <= 1'b1;
            end
            if (is_rw && !bank_open[sdram_ba])
                err[ERR_CLOSED] <= 1'b1;
            if (is_rw && bank_busy[sdram_ba])
                err[ERR_TRCD] <= 1'b1;
            if (is_act && bank_open[sdram_ba])
                err[ERR_REOPEN] <= 1'b1;
        end
    end

    function automatic logic [COL_BITS-1:0] wrap_inc(input logic [COL_BITS-1:0] col,
                                                     input logic [1:0] lg);
        logic [COL_BITS-1:0] mask;
        mask = COL_BITS'((1 << lg) - 1);
        return (col & ~mask) | ((col + COL_BITS'(1)) & mask);
    endfunction

    // Word 0 of a burst is issued on the command edge itself; later words come
    // from the registered burst address.
    always_comb begin
        b_state_n  = b_state;
        b_bank_n   = b_bank;
        b_row_n    = b_row;
        b_col_n    = b_col;
        b_left_n   = b_left;
        b_lg_n     = b_lg;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        issue_addr = {b_bank, b_row, b_col};
        burst_done = 1'b0;
        done_bank  = b_bank;
        if (is_rw) begin
            issue_rd   = is_rd;
            issue_wr   = is_wr;
            issue_addr = {sdram_ba, cmd_row, cmd_col};
            b_bank_n   = sdram_ba;
            b_row_n    = cmd_row;
            b_col_n    = wrap_inc(cmd_col, bl_lg);
            b_lg_n     = bl_lg;
            b_left_n   = 3'((1 << bl_lg) - 1);
            done_bank  = sdram_ba;
            if (bl_lg == 2'd0) begin
                b_state_n  = BURST_IDLE;
                burst_done = 1'b1;
            end else begin
                b_state_n = is_rd ? BURST_READ : BURST_WRITE;
            end
        end else if (is_bt) begin
            b_state_n = BURST_IDLE;
        end else if (sdram_cke && (b_state != BURST_IDLE)) begin
            issue_rd = (b_state == BURST_READ);
            issue_wr = (b_state == BURST_WRITE);
            b_col_n  = wrap_inc(b_col, b_lg);
            b_left_n = b_left - 3'd1;
            if (b_left == 3'd1) begin
                b_state_n  = BURST_IDLE;
                burst_done = 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state <= BURST_IDLE;
            b_bank  <= '0;
            b_row   <= '0;
            b_col   <= '0;
            b_left  <= '0;
            b_lg    <= '0;
        end else begin
            b_state <= b_state_n;
            b_bank  <= b_bank_n;
            b_row   <= b_row_n;
            b_col   <= b_col_n;
            b_left  <= b_left_n;
            b_lg    <= b_lg_n;
        end
    end

    logic [15:0] mem [DEPTH];
    logic [15:0] s0_d, s1_d, out_d;
    logic        s0_v, s1_v, out_v, pipe_flush;

    always_ff @(posedge sdram_clk) begin
        if (sdram_cke) begin
            if (issue_wr) begin
                if (!sdram_dqm[0])
                    mem[issue_addr][7:0] <= sdram_d_i[7:0];
                if (!sdram_dqm[1])
                    mem[issue_addr][15:8] <= sdram_d_i[15:8];
            end
            s0_d <= mem[issue_addr];
            s1_d <= s0_d;
        end
    end

    // A READ only flushes the pipe when it cuts a burst short, so reads issued
    // every BL cycles stream without a gap.
    assign pipe_flush = is_wr || (is_rd && (b_state != BURST_IDLE));
    assign out_v      = (cas_lat == 2'd2) ? s0_v : s1_v;
    assign out_d      = (cas_lat == 2'd2) ? s0_d : s1_d;

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v       <= 1'b0;
            s1_v       <= 1'b0;
            sdram_d_o  <= '0;
            sdram_d_oe <= 1'b0;
        end else if (sdram_cke) begin
            s0_v <= issue_rd;
            s1_v <= s0_v && !pipe_flush;
            if (pipe_flush) begin
                sdram_d_oe <= 1'b0;
            end else begin
                sdram_d_oe <= out_v;
                if (out_v)
                    sdram_d_o <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode, bursts, wrap, masks, truncation,
// clock-enable stalls, reset and error flags.
module tb_sdram_responder;

    localparam logic [3:0] C_LOAD = 4'b0000;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_NOP  = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke;
    logic [3:0]  pins;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic [15:0] d_i;
    logic [15:0] d_o;
    logic        d_oe;
    logic        mode_valid;
    logic [2:0]  err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_responder #(
        .ROW_BITS(2),
        .COL_BITS(6),
        .TRCD    (2)
    ) dut (
        .sdram_clk (clk),
        .rst_n     (rst_n),
        .sdram_cke (cke),
        .sdram_csn (pins[3]),
        .sdram_rasn(pins[2]),
        .sdram_casn(pins[1]),
        .sdram_wen (pins[0]),
        .sdram_a   (addr),
        .sdram_ba  (ba),
        .sdram_dqm (dqm),
        .sdram_d_i (d_i),
        .sdram_d_o (d_o),
        .sdram_d_oe(d_oe),
        .mode_valid(mode_valid),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        pins = c;
        ba   = b;
        addr = a;
        tick();
        pins = C_NOP;
    endtask

    function automatic logic [5:0] wrap_col(input logic [5:0] col, input int unsigned n,
                                            input int unsigned k);
        logic [5:0] m;
        m = 6'(n - 1);
        return (col & ~m) | (6'(col + k) & m);
    endfunction

    task automatic write_burst(input logic [1:0] b, input logic [5:0] col, input int unsigned n,
                               input logic [15:0] base, input bit by_col);
        for (int unsigned k = 0; k < n; k++) begin
            d_i = base + (by_col ? 16'(wrap_col(col, n, k)) : 16'(k));
            if (k == 0) begin
                pins = C_WR;
                ba   = b;
                addr = 13'(col);
            end
            tick();
            pins = C_NOP;
        end
    endtask

    task automatic read_check(input string tag, input logic [1:0] b, input logic [5:0] col,
                              input int unsigned n, input int unsigned cl,
                              input logic [15:0] base, input bit by_col);
        send(C_RD, b, 13'(col));
        repeat (cl - 1) tick();
        for (int unsigned k = 0; k < n; k++) begin
            if (k != 0) tick();
            check({tag, "_oe"}, 32'(d_oe), 32'd1);
            check({tag, "_data"}, 32'(d_o),
                  32'(base + (by_col ? 16'(wrap_col(col, n, k)) : 16'(k))));
        end
        tick();
        check({tag, "_oe_end"}, 32'(d_oe), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        cke   = 1'b1;
        pins  = 4'b1111;
        addr  = '0;
        ba    = '0;
        dqm   = '0;
        d_i   = '0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_d_o", 32'(d_o), 32'd0);
        check("rst_d_oe", 32'(d_oe), 32'd0);
        check("rst_mode_valid", 32'(mode_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pins  = C_NOP;
        tick();

        // CL3 BL4, write then read bank 1 row 2 col 4
        send(C_LOAD, 2'd0, 13'h032);
        check("mode_valid", 32'(mode_valid), 32'd1);
        send(C_ACT, 2'd1, 13'd2);
        tick();
        write_burst(2'd1, 6'd4, 4, 16'hA000, 1'b0);
        check("trcd_ok_err", 32'(err), 32'd0);
        read_check("bl4", 2'd1, 6'd4, 4, 3, 16'hA000, 1'b0);
        check("bl4_err", 32'(err), 32'd0);

        // BL8 wrap from col 6, then back-to-back READs with no gap
        send(C_LOAD, 2'd0, 13'h033);
        write_burst(2'd1, 6'd6, 8, 16'h1000, 1'b1);
        send(C_RD, 2'd1, 13'd6);
        for (int e = 1; e <= 17; e++) begin
            if (e == 8) begin
                pins = C_RD;
                ba   = 2'd1;
                addr = 13'd0;
            end
            tick();
            pins = C_NOP;
            if (e >= 2) begin
                int idx;
                logic [15:0] exp;
                idx = e - 2;
                exp = (idx < 8) ? 16'(16'h1000 + ((6 + idx) & 7)) : 16'(16'h1000 + (idx - 8));
                check("b2b_oe", 32'(d_oe), 32'd1);
                check("b2b_data", 32'(d_o), 32'(exp));
            end
        end
        tick();
        check("b2b_oe_end", 32'(d_oe), 32'd0);

        // Byte mask, CL2, and out-of-range mode codes falling back to CL3/BL1
        send(C_LOAD, 2'd0, 13'h030);
        write_burst(2'd1, 6'd20, 1, 16'hFFFF, 1'b0);
        dqm = 2'b10;
        write_burst(2'd1, 6'd20, 1, 16'h1234, 1'b0);
        dqm = 2'b00;
        read_check("dqm", 2'd1, 6'd20, 1, 3, 16'hFF34, 1'b0);
        send(C_LOAD, 2'd0, 13'h020);
        read_check("cl2", 2'd1, 6'd20, 1, 2, 16'hFF34, 1'b0);
        send(C_LOAD, 2'd0, 13'h075);
        read_check("mode_dflt", 2'd1, 6'd20, 1, 3, 16'hFF34, 1'b0);
        check("mid_err", 32'(err), 32'd0);

        // BL8 READ interrupted by a WRITE three cycles later
        send(C_LOAD, 2'd0, 13'h033);
        send(C_RD, 2'd1, 13'd0);
        tick();
        tick();
        check("trunc_first_oe", 32'(d_oe), 32'd1);
        check("trunc_first_data", 32'(d_o), 32'h1000);
        for (int unsigned k = 0; k < 12; k++) begin
            if (k < 8) begin
                d_i = 16'h2000 + 16'(k);
                if (k == 0) begin
                    pins = C_WR;
                    ba   = 2'd1;
                    addr = 13'd8;
                end
            end
            tick();
            pins = C_NOP;
            check("trunc_oe", 32'(d_oe), 32'd0);
        end
        read_check("trunc_wr", 2'd1, 6'd8, 8, 3, 16'h2000, 1'b0);

        // CKE low for two edges mid-read stretches the stream
        send(C_RD, 2'd1, 13'd0);
        tick();
        tick();
        check("cke_w0", 32'(d_o), 32'h1000);
        tick();
        check("cke_w1", 32'(d_o), 32'h1001);
        cke = 1'b0;
        repeat (2) begin
            tick();
            check("cke_hold_oe", 32'(d_oe), 32'd1);
            check("cke_hold_data", 32'(d_o), 32'h1001);
        end
        cke = 1'b1;
        for (int unsigned k = 2; k < 8; k++) begin
            tick();
            check("cke_oe", 32'(d_oe), 32'd1);
            check("cke_data", 32'(d_o), 32'h1000 + k);
        end
        tick();
        check("cke_oe_end", 32'(d_oe), 32'd0);

        // Asynchronous reset in the middle of a burst
        send(C_RD, 2'd1, 13'd0);
        tick();
        tick();
        tick();
        check("prerst_oe", 32'(d_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_oe", 32'(d_oe), 32'd0);
        check("arst_d_o", 32'(d_o), 32'd0);
        check("arst_mode_valid", 32'(mode_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(C_ACT, 2'd1, 13'd2);
        tick();
        read_check("persist", 2'd1, 6'd3, 1, 3, 16'h1003, 1'b0);
        check("persist_err", 32'(err), 32'd0);
        check("persist_mode_valid", 32'(mode_valid), 32'd0);

        // Error flags
        send(C_PRE, 2'd0, 13'h400);
        send(C_RD, 2'd1, 13'd3);
        check("err_closed", 32'(err), 32'b001);
        tick();
        tick();
        tick();
        send(C_ACT, 2'd3, 13'd0);
        send(C_RD, 2'd3, 13'd0);
        check("err_trcd", 32'(err), 32'b101);
        send(C_ACT, 2'd3, 13'd1);
        check("err_reopen", 32'(err), 32'b111);
        tick();
        tick();
        check("err_sticky", 32'(err), 32'b111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
